// File: rtl/vend_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vend_ctrl : coin-credit vending FSM feeding a 7-segment digit encoder     |
// | Rev 1.0   : initial release                                               |
// +--------------------------------------------------------------------------+
module vend_ctrl #(
    parameter int PRICE_A     = 4,
    parameter int PRICE_B     = 7,
    parameter int MAX_SUM     = 10,
    parameter int HOLD_CYC    = 50,
    parameter int TIMEOUT_CYC = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin1,
    input  logic       coin5,
    input  logic       sel_a,
    input  logic       sel_b,
    input  logic       cancel,
    output logic [3:0] disp_val,
    output logic       disp_mode,
    output logic       vend_a,
    output logic       vend_b,
    output logic [3:0] change_out,
    output logic       coin_reject
);

    localparam int          HW        = $clog2(HOLD_CYC + 1);
    localparam int          TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0]  c_price_a = 4'(PRICE_A);
    localparam logic [3:0]  c_price_b = 4'(PRICE_B);
    localparam logic [4:0]  c_max_sum = 5'(MAX_SUM);
    localparam logic [3:0]  c_idle    = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2,
        S_CHANGE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      sum_q, sum_d;
    logic [3:0]      chg_q, chg_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            item_b_q, item_b_d;
    logic            rej_q, rej_d;

    logic [3:0]      disp_val_q;
    logic            disp_mode_q, vend_a_q, vend_b_q, coin_reject_q;
    logic [3:0]      change_out_q;

    logic            w_one_coin;
    logic            w_any_coin;
    logic            w_any_strobe;
    logic [4:0]      w_val;
    logic [4:0]      w_sum5;
    logic            w_fit;

    assign w_one_coin   = coin1 ^ coin5;
    assign w_any_coin   = coin1 | coin5;
    assign w_any_strobe = w_any_coin | sel_a | sel_b | cancel;
    assign w_val        = coin5 ? 5'd5 : 5'd1;
    assign w_sum5       = {1'b0, sum_q} + w_val;
    assign w_fit        = w_one_coin && (w_sum5 <= c_max_sum);

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        chg_d    = chg_q;
        hold_d   = hold_q;
        tmo_d    = tmo_q;
        item_b_d = item_b_q;
        rej_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (w_fit) begin
                    sum_d   = w_sum5[3:0];
                    tmo_d   = '0;
                    state_d = S_COLLECT;
                end else begin
                    rej_d = w_any_coin;
                end
            end
            S_COLLECT: begin
                tmo_d = w_any_strobe ? '0 : tmo_q + TW'(1);
                // An inactivity timeout behaves exactly like a cancel.
                if (cancel || (!w_any_strobe && tmo_q == TW'(TIMEOUT_CYC - 1))) begin
                    chg_d   = sum_q;
                    sum_d   = '0;
                    hold_d  = '0;
                    rej_d   = w_any_coin;
                    state_d = (sum_q == 4'd0) ? S_IDLE : S_CHANGE;
                end else if (sel_a && sum_q >= c_price_a) begin
                    chg_d    = sum_q - c_price_a;
                    item_b_d = 1'b0;
                    rej_d    = w_any_coin;
                    state_d  = S_VEND;
                end else if (sel_b && sum_q >= c_price_b) begin
                    chg_d    = sum_q - c_price_b;
                    item_b_d = 1'b1;
                    rej_d    = w_any_coin;
                    state_d  = S_VEND;
                end else if (w_fit) begin
                    sum_d = w_sum5[3:0];
                end else begin
                    rej_d = w_any_coin;
                end
            end
            S_VEND: begin
                sum_d   = '0;
                hold_d  = '0;
                rej_d   = w_any_coin;
                state_d = (chg_q != 4'd0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                rej_d = w_any_coin;
                if (hold_q == HW'(HOLD_CYC - 1)) begin
                    chg_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            sum_q         <= '0;
            chg_q         <= '0;
            hold_q        <= '0;
            tmo_q         <= '0;
            item_b_q      <= 1'b0;
            rej_q         <= 1'b0;
            disp_val_q    <= c_idle;
            disp_mode_q   <= 1'b0;
            vend_a_q      <= 1'b0;
            vend_b_q      <= 1'b0;
            change_out_q  <= '0;
            coin_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sum_q         <= sum_d;
            chg_q         <= chg_d;
            hold_q        <= hold_d;
            tmo_q         <= tmo_d;
            item_b_q      <= item_b_d;
            rej_q         <= rej_d;
            // Outputs are decoded from the registered state, one edge behind it.
            disp_val_q    <= (state_q == S_IDLE)   ? c_idle :
                             (state_q == S_CHANGE) ? chg_q  : sum_q;
            disp_mode_q   <= (state_q == S_CHANGE);
            vend_a_q      <= (state_q == S_VEND) && !item_b_q;
            vend_b_q      <= (state_q == S_VEND) &&  item_b_q;
            change_out_q  <= (state_q == S_CHANGE) ? chg_q : 4'd0;
            coin_reject_q <= rej_q;
        end
    end

    assign disp_val    = disp_val_q;
    assign disp_mode   = disp_mode_q;
    assign vend_a      = vend_a_q;
    assign vend_b      = vend_b_q;
    assign change_out  = change_out_q;
    assign coin_reject = coin_reject_q;

endmodule
`default_nettype wire

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
Vending-machine control FSM that sits directly upstream of the seven-segment digit encoder. It accepts coin and selection strobes, accumulates the inserted amount (0..10), issues vend pulses, and computes change. It drives the 4-bit display code the encoder consumes: 0..10 for a value, 4'b1111 for the idle "88" breathing pattern. It also drives a mode flag: 0 means the money sum is shown, 1 means change is shown.

Parameters:
PRICE_A, 4, price of product A (1..10)
PRICE_B, 7, price of product B (1..10)
MAX_SUM, 10, maximum accepted credit; must be <=10 so the display code stays in the encoder range
HOLD_CYC, 50, cycles the change value stays on the display
TIMEOUT_CYC, 500, COLLECT inactivity cycles before an automatic refund

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
coin1  in  1  one-cycle strobe, 1-unit coin inserted
coin5  in  1  one-cycle strobe, 5-unit coin inserted
sel_a  in  1  one-cycle strobe, select product A
sel_b  in  1  one-cycle strobe, select product B
cancel  in  1  one-cycle strobe, refund all credit
disp_val  out  4  display code to encoder: 0..10, or 4'b1111 when idle
disp_mode  out  1  0 = credit sum, 1 = change
vend_a  out  1  one-cycle pulse, dispense A
vend_b  out  1  one-cycle pulse, dispense B
change_out  out  4  change amount, valid while in CHANGE, else 0
coin_reject  out  1  one-cycle pulse, coin returned uncredited

Behaviour:
- One clock; reset is synchronous and active-low (rst_n sampled on rising clk).
- All outputs are registered. An event sampled at edge N is visible after edge N+1.
- Reset values: state=IDLE, sum=0, disp_val=4'b1111, disp_mode=0, vend_a=vend_b=0, change_out=0, coin_reject=0, all counters 0.
- A reset asserted mid-operation forces IDLE on the next edge. Any accrued credit is discarded; no vend and no change are issued.
- States: IDLE, COLLECT, VEND, CHANGE.
- Coin value: coin1 alone = 1; coin5 alone = 5; both in the same cycle = error, both rejected (coin_reject=1), sum unchanged.
- A coin is accepted only if sum + value <= MAX_SUM. Otherwise coin_reject pulses and sum is unchanged. Width: use a 5-bit intermediate for the compare; sum is stored in 4 bits.
- IDLE:
  - disp_val=4'b1111, disp_mode=0.
  - An accepted coin sets sum=value and moves to COLLECT.
  - sel_a, sel_b and cancel are ignored.
- COLLECT:
  - disp_val=sum, disp_mode=0.
  - Priority per cycle: cancel > sel_a > sel_b > coin.
  - cancel: change=sum, go to CHANGE (if sum=0, go to IDLE).
  - sel_a with sum>=PRICE_A: go to VEND, change=sum-PRICE_A. Same for sel_b with PRICE_B.
  - A selection with insufficient credit is ignored. State and sum are unchanged and no pulse is issued.
  - A coin in the same cycle as an accepted cancel or selection is rejected (coin_reject=1).
  - The inactivity counter resets on any input strobe. Reaching TIMEOUT_CYC is treated as cancel.
- VEND (exactly 1 cycle):
  - vend_a or vend_b=1 for one cycle and sum cleared.
  - Next state is CHANGE if change>0, else IDLE.
  - Coins arriving in VEND are rejected.
- CHANGE:
  - disp_val=change, disp_mode=1, change_out=change for HOLD_CYC cycles, then IDLE with change_out=0.
  - All strobes are ignored; coins are rejected.
- disp_val never takes the values 11..14.

Test Plan:
1. Reset, then idle 5 cycles -> disp_val=4'b1111, disp_mode=0, no pulses.
2. coin5, coin1 (PRICE_A=4), then sel_a -> disp_val 5, then 6; one vend_a pulse; then disp_mode=1, disp_val=2, change_out=2 for 50 cycles; then disp_val=4'b1111.
3. coin5, coin5, then coin1 -> sum 10 shown as disp_val=10; third coin gives coin_reject, sum stays 10. Then sel_b -> vend_b, change 3.
4. coin1 then sel_b (sum 1 < 7) -> no vend_b, disp_val stays 1. cancel -> CHANGE with change_out=1.
5. coin1 and coin5 in the same cycle -> coin_reject, stays IDLE. coin1 together with sel_a when sum=4 -> vend_a and coin_reject, change 0, direct return to IDLE.
6. Credit 6, no input for TIMEOUT_CYC -> auto refund, change_out=6. rst_n low during CHANGE -> IDLE and change_out=0 after the next edge.
